rcon_sched: RTL and testbench
=============================

Name: rcon_sched

Overview:
- Sequential round-constant and key-schedule control sequencer for the AES key-expansion datapath.
- Supports AES-128, AES-192 and AES-256, selected at run time.
- Computes Rcon iteratively by GF(2^8) doubling instead of a fixed lookup.
- Steps one expanded word at a time under a consumer handshake, and tells the datapath per word whether RotWord, SubWord and Rcon apply.

Parameters:
- OUT_W, 32, width of rcon_out. Must be >= 8. The Rcon byte occupies bits [OUT_W-1:OUT_W-8]; all other bits are 0.
- POLY, 8'h1b, reduction byte XORed in on doubling overflow.
- RCON_INIT, 8'h01, Rcon value for the first word with i mod Nk == 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a schedule; sampled only in IDLE.
- mode  input  2  key size: 0 = 128 (Nk=4, Nw=44), 1 = 192 (Nk=6, Nw=52), 2 = 256 (Nk=8, Nw=60), 3 = illegal. Sampled with start.
- advance  input  1  consumer accepts the current word; effective only when word_valid=1.
- busy  output  1  high in RUN.
- word_valid  output  1  outputs below describe expanded word word_idx.
- word_idx  output  6  current word index i, from Nk to Nw-1.
- need_rot  output  1  i mod Nk == 0.
- need_sub  output  1  need_rot, or (Nk == 8 and i mod 8 == 4).
- rcon_out  output  OUT_W  Rcon byte placed in the MSBs when need_rot=1; 0 otherwise.
- done  output  1  one-cycle pulse after the last word is accepted.
- err_mode  output  1  one-cycle pulse when start arrives with mode=3.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. Internal i=0, nk_cnt=0, rcon=RCON_INIT.
- States: IDLE, RUN, DONE.
- IDLE, start=1, mode<3:
  - latch Nk and Nw; i=Nk, nk_cnt=0, rcon=RCON_INIT.
  - next state RUN. word_valid rises the cycle after the start edge (1-cycle latency).
- IDLE, start=1, mode=3:
  - err_mode=1 for exactly one cycle; remain IDLE; no other output changes.
- RUN:
  - word_valid=1, busy=1.
  - Outputs are combinational from registered i, nk_cnt, rcon, Nk.
  - Outputs hold while advance=0.
- RUN, advance=1 and i < Nw-1:
  - i <= i+1.
  - nk_cnt <= (nk_cnt == Nk-1) ? 0 : nk_cnt+1.
  - If nk_cnt == 0 (Rcon just consumed): rcon <= {rcon[6:0],1'b0} ^ (rcon[7] ? POLY : 8'h00).
- RUN, advance=1 and i == Nw-1:
  - next state DONE; word_valid, busy and all word outputs go to 0 in the next cycle.
- DONE: done=1 for one cycle, then IDLE unconditionally. start during DONE is ignored.
- start during RUN or DONE is ignored; latched mode is unaffected by changes to mode.
- Only advance while word_valid=1 has effect.
- The i mod 8 == 4 term for need_sub uses nk_cnt == 4 and applies only when Nk == 8.
- Rcon sequence is 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - 128 uses 10 values.
  - 192 uses 8 values (i = 6..48).
  - 256 uses 7 values (i = 8..56).
  - No wrap beyond 36 occurs in legal operation.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. The next start restarts at i=Nk, rcon=RCON_INIT.
- In IDLE and DONE: word_idx=0, need_rot=0, need_sub=0, rcon_out=0.

Test Plan:
- mode=0, start, advance held high: need_rot at i=4, 8, ..., 40 with rcon_out MSB byte 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Other bytes 0. done pulses one cycle after 40th advance. busy low thereafter.
- mode=1, advance high: need_rot exactly at i=6, 12, ..., 48 with bytes 01..80. need_sub equals need_rot. Last word i=51. done after 46 advances.
- mode=2, advance high: need_rot at i=8, ..., 56 with bytes 01..40. need_sub=1 with need_rot=0 and rcon_out=0 at i=12, 20, 28, 36, 44, 52. Last word i=59.
- mode=0, advance randomly deasserted for 1-5 cycles: all outputs stable while advance=0. Final trace of (word_idx, need_rot, rcon_out) identical to the uninterrupted run. start pulsed mid-run has no effect.
- start with mode=3: err_mode high exactly one cycle; busy and word_valid remain 0. A following start with mode=0 runs normally.
- mode=2 run, assert rst_n=0 asynchronously at word_idx=20: all outputs 0 before the next clock edge. After release, start with mode=0 yields word_idx=4, need_rot=1, rcon_out MSB byte=01.

Source files
------------

// File: rtl/rcon_sched_if.sv
// Handshake and word-descriptor bundle between the key-schedule sequencer
// and the consumer that drives start/advance and reads per-word controls.
interface rcon_sched_if #(
  parameter int OUT_W = 32
) ();
  logic             start;
  logic [1:0]       mode;
  logic             advance;
  logic             busy;
  logic             word_valid;
  logic [5:0]       word_idx;
  logic             need_rot;
  logic             need_sub;
  logic [OUT_W-1:0] rcon_out;
  logic             done;
  logic             err_mode;

  modport master (
    output start, mode, advance,
    input  busy, word_valid, word_idx, need_rot, need_sub, rcon_out, done, err_mode
  );

  modport slave (
    input  start, mode, advance,
    output busy, word_valid, word_idx, need_rot, need_sub, rcon_out, done, err_mode
  );
endinterface

// File: rtl/rcon_sched.sv
// AES key-expansion control sequencer: walks expanded words Nk..Nw-1 and
// flags RotWord/SubWord/Rcon per word, generating Rcon by GF(2^8) doubling.
module rcon_sched #(
  parameter int         OUT_W     = 32,
  parameter logic [7:0] POLY      = 8'h1b,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  rcon_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e     state_q;
  logic [5:0] iIdx_q;
  logic [5:0] iIdx_d;
  logic [2:0] nkCnt_q;
  logic [2:0] nkCnt_d;
  logic [7:0] rcon_q;
  logic [7:0] rcon_d;
  logic [3:0] nk_q;
  logic [5:0] nw_q;
  logic       errMode_q;

  logic [3:0] startNk;
  logic [5:0] startNw;
  logic       lastWord;
  logic       running;
  logic       rotHere;
  logic       subHere;

  always_comb begin
    startNk = 4'd4;
    startNw = 6'd44;
    case (bus.mode)
      2'd1: begin
        startNk = 4'd6;
        startNw = 6'd52;
      end
      2'd2: begin
        startNk = 4'd8;
        startNw = 6'd60;
      end
      default: begin
        startNk = 4'd4;
        startNw = 6'd44;
      end
    endcase
  end

  // nkCnt tracks i mod Nk; Rcon advances only once the word that used it is accepted.
  always_comb begin
    lastWord = (iIdx_q == (nw_q - 6'd1));
    iIdx_d   = iIdx_q + 6'd1;
    nkCnt_d  = ({1'b0, nkCnt_q} == (nk_q - 4'd1)) ? 3'd0 : nkCnt_q + 3'd1;
    rcon_d   = rcon_q;
    if (nkCnt_q == 3'd0) begin
      rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iIdx_q    <= '0;
      nkCnt_q   <= '0;
      rcon_q    <= RCON_INIT;
      nk_q      <= '0;
      nw_q      <= '0;
      errMode_q <= 1'b0;
    end else begin
      errMode_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.mode == 2'd3) begin
              errMode_q <= 1'b1;
            end else begin
              nk_q    <= startNk;
              nw_q    <= startNw;
              iIdx_q  <= {2'b00, startNk};
              nkCnt_q <= '0;
              rcon_q  <= RCON_INIT;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.advance) begin
            if (lastWord) begin
              state_q <= DONE;
            end else begin
              iIdx_q  <= iIdx_d;
              nkCnt_q <= nkCnt_d;
              rcon_q  <= rcon_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The i mod 8 == 4 SubWord-only slot exists only for 256-bit keys.
  always_comb begin
    running = (state_q == RUN);
    rotHere = running && (nkCnt_q == 3'd0);
    subHere = rotHere || (running && (nk_q == 4'd8) && (nkCnt_q == 3'd4));
  end

  assign bus.busy       = running;
  assign bus.word_valid = running;
  assign bus.word_idx   = running ? iIdx_q : 6'd0;
  assign bus.need_rot   = rotHere;
  assign bus.need_sub   = subHere;
  assign bus.rcon_out   = rotHere ? (OUT_W'(rcon_q) << (OUT_W - 8)) : '0;
  assign bus.done       = (state_q == DONE);
  assign bus.err_mode   = errMode_q;

endmodule

// File: tb/tb_rcon_sched.sv
// Randomised bench for rcon_sched: a word-level reference model checked every
// cycle, plus literal pins on the Rcon sequence and schedule boundaries.
module tb_rcon_sched;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rcon_sched_if #(.OUT_W(32)) bus ();

  rcon_sched #(.OUT_W(32), .POLY(8'h1b), .RCON_INIT(8'h01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rconTbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Reference model: phase 0 idle, 1 running, 2 done.
  int mPhase = 0;
  int mI     = 0;
  int mNk    = 0;
  int mNw    = 0;
  bit mErr   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = 0;
      mI     = 0;
      mNk    = 0;
      mNw    = 0;
      mErr   = 1'b0;
    end else begin
      mErr = 1'b0;
      case (mPhase)
        0: if (bus.start) begin
          if (bus.mode == 2'd3) begin
            mErr = 1'b1;
          end else begin
            mNk    = 4 + 2 * int'(bus.mode);
            mNw    = 4 * (mNk + 7);
            mI     = mNk;
            mPhase = 1;
          end
        end
        1: if (bus.advance) begin
          if (mI == mNw - 1) mPhase = 2;
          else mI = mI + 1;
        end
        default: mPhase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit          recOn = 1'b0;
  logic [15:0] trace  [$];
  logic [15:0] trace0 [$];

  always @(negedge clk) begin
    bit          eValid;
    bit          eRot;
    bit          eSub;
    logic [31:0] eRcon;
    int          eIdx;
    eValid = (mPhase == 1);
    eRot   = 1'b0;
    eSub   = 1'b0;
    eRcon  = 32'h0;
    eIdx   = 0;
    if (eValid) begin
      eIdx = mI;
      eRot = (mI % mNk) == 0;
      eSub = eRot || (mNk == 8 && (mI % 8) == 4);
      if (eRot) eRcon = {rconTbl[mI / mNk - 1], 24'h0};
    end
    checkOutput("busy", 32'(bus.busy), 32'(eValid));
    checkOutput("word_valid", 32'(bus.word_valid), 32'(eValid));
    checkOutput("word_idx", 32'(bus.word_idx), 32'(eIdx));
    checkOutput("need_rot", 32'(bus.need_rot), 32'(eRot));
    checkOutput("need_sub", 32'(bus.need_sub), 32'(eSub));
    checkOutput("rcon_out", bus.rcon_out, eRcon);
    checkOutput("done", 32'(bus.done), 32'(mPhase == 2));
    checkOutput("err_mode", 32'(bus.err_mode), 32'(mErr));
    if (recOn && bus.word_valid && bus.advance)
      trace.push_back({bus.word_idx, bus.need_rot, bus.need_sub, bus.rcon_out[31:24]});
  end

  // One full schedule: optional random stalls and a stray start mid-run.
  task automatic applyStimulus(input logic [1:0] m, input bit stall, input bit midStart);
    int cyc;
    int stallLeft;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = 2'($urandom_range(0, 3));
    seen      = 1'b0;
    cyc       = 0;
    stallLeft = 0;
    while (!seen && cyc < 400) begin
      if (stallLeft > 0) begin
        bus.advance = 1'b0;
        stallLeft--;
      end else begin
        bus.advance = 1'b1;
        if (stall && $urandom_range(0, 2) == 0) stallLeft = $urandom_range(1, 5);
      end
      bus.start = midStart && (cyc == 10 || cyc == 30);
      if (bus.start) bus.mode = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
      cyc++;
    end
    bus.advance = 1'b0;
    bus.start   = 1'b0;
    checkOutput("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic pinTrace(input int nk, input int expLen, input int expRots);
    logic [7:0] litBytes [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    int subOnly [6] = '{12, 20, 28, 36, 44, 52};
    int k;
    int s;
    k = 0;
    s = 0;
    foreach (trace[n]) begin
      if (trace[n][9]) begin
        checkOutput("rot_idx", 32'(trace[n][15:10]), 32'(nk * (k + 1)));
        if (k < 10) checkOutput("rot_byte", 32'(trace[n][7:0]), 32'(litBytes[k]));
        k++;
      end else begin
        checkOutput("norot_byte", 32'(trace[n][7:0]), 32'h0);
      end
      if (nk == 8 && trace[n][8] && !trace[n][9]) begin
        if (s < 6) checkOutput("subonly_idx", 32'(trace[n][15:10]), 32'(subOnly[s]));
        s++;
      end
      if (nk == 6) checkOutput("sub_eq_rot", 32'(trace[n][8]), 32'(trace[n][9]));
    end
    checkOutput("rot_count", 32'(k), 32'(expRots));
    checkOutput("trace_len", 32'(trace.size()), 32'(expLen));
    if (trace.size() > 0) begin
      checkOutput("first_idx", 32'(trace[0][15:10]), 32'(nk));
      checkOutput("last_idx", 32'(trace[trace.size()-1][15:10]), 32'(nk + expLen - 1));
    end
    if (nk == 8) checkOutput("subonly_count", 32'(s), 32'd6);
  endtask

  initial begin
    int cyc;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 2'd0;
    bus.advance = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_rcon", bus.rcon_out, 32'd0);
    rst_n = 1'b1;

    $display("[TB] AES-128 uninterrupted");
    trace.delete();
    recOn = 1'b1;
    applyStimulus(2'd0, 1'b0, 1'b0);
    recOn = 1'b0;
    pinTrace(4, 40, 10);
    trace0 = trace;
    @(posedge clk); #1;
    checkOutput("busy_after_done", 32'(bus.busy), 32'd0);

    $display("[TB] AES-192 uninterrupted");
    trace.delete();
    recOn = 1'b1;
    applyStimulus(2'd1, 1'b0, 1'b0);
    recOn = 1'b0;
    pinTrace(6, 46, 8);

    $display("[TB] AES-256 uninterrupted");
    trace.delete();
    recOn = 1'b1;
    applyStimulus(2'd2, 1'b0, 1'b0);
    recOn = 1'b0;
    pinTrace(8, 52, 7);

    $display("[TB] AES-128 with stalls and stray start");
    trace.delete();
    recOn = 1'b1;
    applyStimulus(2'd0, 1'b1, 1'b1);
    recOn = 1'b0;
    checkOutput("stall_len", 32'(trace.size()), 32'(trace0.size()));
    foreach (trace[n]) begin
      if (n < trace0.size()) checkOutput("stall_trace", 32'(trace[n]), 32'(trace0[n]));
    end

    $display("[TB] illegal mode");
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.mode  = 2'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("err_pulse", 32'(bus.err_mode), 32'd1);
    checkOutput("err_wv", 32'(bus.word_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("err_clear", 32'(bus.err_mode), 32'd0);
    checkOutput("err_busy", 32'(bus.busy), 32'd0);
    applyStimulus(2'd0, 1'b0, 1'b0);

    $display("[TB] async reset mid AES-256");
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.mode  = 2'd2;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.advance = 1'b1;
    cyc = 0;
    while (bus.word_idx != 6'd20 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("reach_idx20", 32'(bus.word_idx), 32'd20);
    bus.advance = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_wv", 32'(bus.word_valid), 32'd0);
    checkOutput("rst_idx", 32'(bus.word_idx), 32'd0);
    checkOutput("rst_rot", 32'(bus.need_rot), 32'd0);
    checkOutput("rst_rcon", bus.rcon_out, 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.mode  = 2'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("restart_idx", 32'(bus.word_idx), 32'd4);
    checkOutput("restart_rot", 32'(bus.need_rot), 32'd1);
    checkOutput("restart_rcon", bus.rcon_out, 32'h0100_0000);
    bus.advance = 1'b1;
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.advance = 1'b0;
    checkOutput("restart_done", 32'(bus.done), 32'd1);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
